// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: byte handshake, raw line levels, open-drain enables and status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;

  // master: the environment that supplies bytes and line levels.
  modport master (
    output tx_data, tx_valid, ps2_clk, ps2_data,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
  );

  // slave: the transmitter itself.
  modport slave (
    input  tx_data, tx_valid, ps2_clk, ps2_data,
    output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 10 clocked bits, ack).
// Macro PS2_TX_ACK_CHECK_EN: when defined, a high data line in the ack slot is reported as error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic         clk,
  input logic         clrn,
  ps2_host_tx_if.slave bus
);

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK} state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [9:0]    frame;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic          clk_oe, data_oe, ready, busy_q, done_q, error_q;
  logic          fall;

  assign fall = clk_sync[2] & ~clk_sync[1];

  // NOTE: every register here is assigned with <= so all state updates see pre-edge values;
  // synchronizers reset to ones because both PS/2 lines idle high, so no false edge follows reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      clk_sync  <= '1;
      data_sync <= '1;
      frame     <= '1;
      idx       <= '0;
      cnt       <= '0;
      clk_oe    <= 1'b0;
      data_oe   <= 1'b0;
      ready     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      done_q    <= 1'b0;
      error_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            frame  <= {1'b1, ~^bus.tx_data, bus.tx_data};
            cnt    <= '0;
            clk_oe <= 1'b1;
            ready  <= 1'b0;
            busy_q <= 1'b1;
            state  <= INHIBIT;
          end
        end

        INHIBIT: begin
          cnt <= cnt + 1'b1;
          // Start bit goes out one cycle early so it overlaps the last inhibit cycle.
          if (cnt == CW'(INHIBIT_CYCLES - 2)) data_oe <= 1'b1;
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            clk_oe <= 1'b0;
            cnt    <= '0;
            state  <= REQ;
          end
        end

        REQ, SEND, ACK: begin
          if (state == REQ) begin
            idx   <= '0;
            cnt   <= cnt + 1'b1;
            state <= SEND;
          end else if (fall) begin
            cnt <= '0;
            if (state == SEND) begin
              data_oe <= ~frame[idx];
              if (idx == 4'd9) state <= ACK;
              else             idx   <= idx + 1'b1;
            end else begin
              if (ACK_CHECK && data_sync[1]) error_q <= 1'b1;
              else                           done_q  <= 1'b1;
              data_oe <= 1'b0;
              ready   <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            ready   <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = ready;
  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and bit/result scoreboards.
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TO  = 2000;
  localparam int H   = 20;   // device clock half period in system cycles

`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic NACK_IS_ERROR = 1'b1;
`else
  localparam logic NACK_IS_ERROR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int compared = 0;
  int mismatched = 0;
  bit exp_bits[$];
  bit exp_res[$];   // 0 = done expected, 1 = error expected

  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  // Open-drain wired-AND between device and host.
  assign bus.ps2_clk  = dev_clk  & ~bus.ps2_clk_oe;
  assign bus.ps2_data = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every done/error pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (clrn && (bus.done || bus.error)) begin
      check("done_error_exclusive", 32'(bus.done & bus.error), 32'd0);
      check("result_pending", 32'(exp_res.size() > 0), 32'd1);
      if (exp_res.size() > 0) check("result_kind", 32'(bus.error), 32'(exp_res.pop_front()));
    end
  end

  task automatic start_frame(input logic [7:0] d);
    int n;
    int first;
    logic [9:0] f;
    f = {1'b1, logic'(($countones(d) % 2) == 0), d};
    @(negedge clk);
    check("ready_idle", 32'(bus.tx_ready), 32'd1);
    check("busy_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 10; i++) exp_bits.push_back(f[i]);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("ready_busy", 32'(bus.tx_ready), 32'd0);
    check("busy_set", 32'(bus.busy), 32'd1);
    bus.tx_data = ~d;   // must be ignored while busy
    n = 0;
    first = 0;
    while (bus.ps2_clk_oe && n < INH + 10) begin
      n++;
      if (bus.ps2_data_oe && first == 0) first = n;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("inhibit_len", 32'(n), 32'(INH));
    check("start_bit_cycle", 32'(first), 32'(INH));
    check("start_bit_line", 32'(bus.ps2_data), 32'd0);
  endtask

  task automatic device_clock(input logic ack, input int abort_after);
    int n;
    repeat (H) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 dev_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 dev_clk = 1'b1;
      check($sformatf("frame_bit%0d", i), 32'(bus.ps2_data), 32'(exp_bits.pop_front()));
      if (i + 1 == abort_after) begin
        #2 clrn = 1'b0;
        #1;
        check("abort_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("abort_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        check("abort_pulses", 32'({bus.done, bus.error}), 32'd0);
        check("abort_ready", 32'(bus.tx_ready), 32'd1);
        exp_bits.delete();
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        return;
      end
      repeat (H) @(posedge clk);
    end
    #1 dev_data = ack;
    repeat (H / 2) @(posedge clk);
    #1 dev_clk = 1'b0;
    repeat (H) @(posedge clk);
    #1 dev_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 dev_data = 1'b1;
    n = 0;
    while (exp_res.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("result_seen", 32'(exp_res.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("ready_after", 32'(bus.tx_ready), 32'd1);
    check("data_released", 32'(bus.ps2_data_oe), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack, input logic exp_err);
    exp_res.push_back(exp_err);
    start_frame(d);
    device_clock(ack, 0);
  endtask

  initial begin
    int n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #12;
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    check("rst_pulses", 32'({bus.done, bus.error}), 32'd0);
    #10 clrn = 1'b1;
    repeat (5) @(posedge clk);

    send_byte(8'hED, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h96, 1'b1, NACK_IS_ERROR);

    // Device never clocks: the timeout must fire exactly TO cycles after the request.
    exp_res.push_back(1'b1);
    start_frame(8'hA5);
    n = 0;
    while (!bus.error && n < TO + 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("timeout_cycle", 32'(n), 32'(TO));
    check("timeout_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    exp_bits.delete();
    @(negedge clk);
    check("timeout_result", 32'(exp_res.size()), 32'd0);
    check("timeout_ready", 32'(bus.tx_ready), 32'd1);

    // Reset after four data bits, then a clean frame.
    start_frame(8'hED);
    device_clock(1'b0, 5);
    repeat (10) @(negedge clk);
    check("abort_no_result", 32'(exp_res.size()), 32'd0);
    send_byte(8'h3C, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check("final_pending", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, SHALL set the clk cycles the PS/2 clock line is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, SHALL set the max clk cycles allowed between device clock falling edges (15 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request; the byte is accepted on a cycle with tx_valid=1 and tx_ready=1.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk  input  1  raw PS/2 clock line level.
REQ-009 ps2_data  input  1  raw PS/2 data line level.
REQ-010 ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release (open-drain).
REQ-011 ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release (open-drain).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 error  output  1  one-cycle pulse on timeout or missing ack.

Function
REQ-015 ps2_clk SHALL pass through a 3-flop shift synchronizer; a falling edge is sync[2]=1 and sync[1]=0; ps2_data SHALL pass through a 2-flop synchronizer.
REQ-016 States: IDLE, INHIBIT, REQ, SEND, ACK; ack and error pulses SHALL be issued on the transition back to IDLE.
REQ-017 IDLE -> INHIBIT on accept; latch tx_data into a 10-bit frame {stop=1, odd parity, data[7:0]} with parity = ~^tx_data.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe SHALL assert in the final inhibit cycle.
REQ-019 REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit); -> SEND with bit index 0.
REQ-020 SEND: on each falling edge, ps2_data_oe = ~frame[index] and index increments; bits go LSB first, then parity, then stop.
REQ-021 After the falling edge that presents the stop bit (index 9), ps2_data_oe SHALL be 0 and the FSM SHALL enter ACK.
REQ-022 ACK: on the next falling edge, sampled data=0 -> done pulse; data=1 -> error pulse; both return to IDLE.
REQ-023 A cycle counter SHALL clear on every falling edge and on entering REQ.
REQ-024 If the cycle counter reaches TIMEOUT_CYCLES in REQ, SEND or ACK: error pulse, both oe outputs =0, -> IDLE.
REQ-025 tx_valid outside IDLE SHALL be ignored; the latched frame SHALL remain stable until IDLE.
REQ-026 done and error SHALL never assert in the same cycle.

Reset
REQ-027 clrn=0 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, error=0, and clear counters, frame and synchronizers to all-ones.
REQ-028 Reset mid-frame SHALL abort the frame with no done or error pulse.

Configuration
REQ-029 Macro PS2_TX_ACK_CHECK_EN defined: ACK behaves per REQ-022.
REQ-030 Macro PS2_TX_ACK_CHECK_EN undefined: ACK issues done on the next falling edge regardless of data level, and error is raised only by timeout.

Verification
REQ-031 Device model clocks at 12.5 kHz, tx_data=8'hED -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen on rising edges; ack=0 -> done pulse once; tx_ready returns high.
REQ-032 tx_data=8'h00 -> parity bit 1; tx_data=8'h01 -> parity bit 0.
REQ-033 Accept a byte -> ps2_clk_oe high for exactly 5000 cycles, and ps2_data_oe rises in cycle 5000.
REQ-034 Device never clocks after REQ -> error pulse at cycle 750000; both oe outputs =0.
REQ-035 Device ack=1 -> error pulse with PS2_TX_ACK_CHECK_EN defined; done pulse with it undefined.
REQ-036 clrn low after 4 data bits -> oe outputs =0 asynchronously, no pulses; a new byte then completes normally.
